pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Program-counter controller. Owns the 11-bit PC register and sequences the PC adder each cycle.
//  Next PC is one of: increment, PC-relative branch, absolute jump, or hold. It emits a one-cycle
//  fetch bubble/flush on every redirect. Sits between the decode/branch logic and instruction memory.
// PARAMETERS
//  PC_W         11      PC width; the adder datapath is fixed at 11 bits, so PC_W must stay 11
//  RESET_PC     11'h000 PC value loaded by reset
//  STACK_DEPTH  4       return-stack entries; used only with PC_CALL_STACK_EN
// PORTS
//  clk           in   1     single clock; all state updates on the rising edge
//  rst           in   1     synchronous, active-high reset
//  stall         in   1     hold PC and state; redirect inputs are ignored while high
//  jump          in   1     absolute redirect to jump_addr
//  jump_addr     in   11    jump target
//  branch_taken  in   1     relative redirect: PC + branch_off
//  branch_off    in   11    two's-complement offset, relative to current pc
//  call          in   1     push pc+1 onto the return stack, then jump to jump_addr (macro only)
//  ret           in   1     pop the return stack into PC (macro only)
//  pc            out  11    current fetch address
//  pc_valid      out  1     pc is a real fetch (low during bubble cycles)
//  flush         out  1     one-cycle pulse; younger in-flight instruction must be discarded
//  stack_err     out  1     sticky; set on push-when-full or pop-when-empty (macro only)
// BEHAVIOUR
//  - Reset (rst=1 at the edge): pc=RESET_PC, pc_valid=0, flush=0, stack_err=0, stack empty,
//    state=S_BOOT. Reset overrides everything, including mid-redirect and mid-stall.
//  - FSM states: S_BOOT, S_RUN, S_BUBBLE.
//    S_BOOT: pc_valid=0; the next cycle enters S_RUN with pc unchanged (RESET_PC).
//    S_RUN: pc_valid=1.
//      stall=1: hold pc.
//      Otherwise, priority ret > call > jump > branch_taken > increment.
//      Any redirect loads the new pc, asserts flush for one cycle, and enters S_BUBBLE.
//    S_BUBBLE: pc_valid=0, pc holds, redirect inputs are ignored; the next cycle enters S_RUN.
//      While stall=1, S_BUBBLE is held.
//  - Latency: redirect at edge N gives the new pc at N+1 with pc_valid=0, and valid at N+2.
//  - Arithmetic: every sum is modulo 2^11; 11'h7FF+1 -> 11'h000. The branch sum is pc + branch_off.
//    There is no overflow flag.
//  - Inputs are sampled only in S_RUN with stall=0. The requester holds a redirect through a stall.
//  - Without the macro, call/ret are ignored and stack_err is tied to 0.
// CONFIGURATION
//  PC_CALL_STACK_EN defined: return stack of STACK_DEPTH x 11 bits.
//    call pushes pc+1 and redirects to jump_addr.
//    ret pops and redirects to the popped value.
//    Push when full: the push is dropped, call still redirects, stack_err is set.
//    Pop when empty: pc becomes RESET_PC and stack_err is set.
//    Simultaneous call+ret: ret wins and there is no push.
//  PC_CALL_STACK_EN undefined: no stack storage; call and ret are ignored.
// STRUCTURE
//  - Shared package pc_pkg: PC_W, RESET_PC default, state encoding (S_BOOT/S_RUN/S_BUBBLE),
//    next-pc select enum (SEL_HOLD/SEL_INC/SEL_BR/SEL_JMP/SEL_RET).
//  - Two instances of the team's Adder_10bit: one computes pc+1, one computes pc+branch_off.
//  - One sub-module, pc_return_stack (push/pop/full/empty, sync reset), instantiated only under
//    PC_CALL_STACK_EN.
// TESTING
//  1. rst=1 for 2 cycles, then release
//     -> pc=000, pc_valid 0,0,1; pc=000,001,002 on the following cycles.
//  2. Force pc=7FE via jump, run freely -> pc 7FE, 7FF, 000 (wrap), no flush on the wrap.
//  3. At pc=010, branch_taken with branch_off=11'h7FC (-4)
//     -> pc=00C, flush pulse one cycle, pc_valid=0 one cycle.
//  4. jump=1 (addr 123) and branch_taken=1 in the same cycle
//     -> pc=123; a jump held through a 3-cycle stall is taken on the first unstalled cycle.
//  5. rst asserted during S_BUBBLE -> next cycle pc=RESET_PC, flush=0, state S_BOOT.
//  6. Macro on: call at pc=020 (addr 200), then ret -> pc 200, later 021.
//     5 nested calls -> stack_err=1. ret on an empty stack -> pc=RESET_PC.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: widths, reset
// address, FSM state encoding and the next-pc select encoding.
package pc_pkg;

    localparam int          PC_W     = 11;
    localparam logic [10:0] RESET_PC = 11'h000;

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_RUN    = 2'd1,
        S_BUBBLE = 2'd2
    } pc_state_e;

    typedef enum logic [2:0] {
        SEL_HOLD = 3'd0,
        SEL_INC  = 3'd1,
        SEL_BR   = 3'd2,
        SEL_JMP  = 3'd3,
        SEL_RET  = 3'd4
    } pc_sel_e;

    // True when the select code moves the PC somewhere other than pc+1/hold.
    function automatic logic is_redirect(input pc_sel_e sel);
        return (sel == SEL_BR) || (sel == SEL_JMP) || (sel == SEL_RET);
    endfunction

endpackage

// File: rtl/Adder_10bit.sv
// Shared adder block used for PC arithmetic. The datapath is 11 bits wide
// despite the historical name; the sum wraps modulo 2^11 with no carry out.
module Adder_10bit (
    input  logic [10:0] i_a,
    input  logic [10:0] i_b,
    output logic [10:0] o_sum
);

    assign o_sum = i_a + i_b;

endmodule

// File: rtl/pc_return_stack.sv
// Return-address stack for call/ret. Push is dropped when full and pop is a
// no-op when empty; the caller decides what to do about either condition.
// Only instantiated when PC_CALL_STACK_EN is defined.
module pc_return_stack #(
    parameter int PC_W  = 11,
    parameter int DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [PC_W-1:0] i_push_data,
    output logic [PC_W-1:0] o_top,
    output logic            o_full,
    output logic            o_empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PC_W-1:0] r_mem [DEPTH];
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   w_top_idx;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == {CW{1'b0}});
    assign w_top_idx = AW'(r_count - CW'(1));
    assign o_top     = r_mem[w_top_idx];

    // Stack storage and occupancy; push and pop are never requested together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {PC_W{1'b0}};
            end
        end else if (i_push && !o_full) begin
            r_mem[AW'(r_count)] <= i_push_data;
            r_count             <= r_count + CW'(1);
        end else if (i_pop && !o_empty) begin
            r_count <= r_count - CW'(1);
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter controller: owns the PC register, picks increment /
// branch / jump / return each cycle and inserts a one-cycle bubble with a
// flush pulse after every redirect.
// Optional feature: define PC_CALL_STACK_EN to enable call/ret and the
// return stack; otherwise call/ret are ignored and o_stack_err stays 0.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int               PC_W        = pc_pkg::PC_W,
    parameter logic [PC_W-1:0]  RESET_PC    = pc_pkg::RESET_PC,
    parameter int               STACK_DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_stall,
    input  logic            i_jump,
    input  logic [PC_W-1:0] i_jump_addr,
    input  logic            i_branch_taken,
    input  logic [PC_W-1:0] i_branch_off,
    input  logic            i_call,
    input  logic            i_ret,
    output logic [PC_W-1:0] o_pc,
    output logic            o_pc_valid,
    output logic            o_flush,
    output logic            o_stack_err
);

    pc_state_e       r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_pc_valid;
    logic            r_flush;
    logic            r_stack_err;

    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_pc_br;
    logic [PC_W-1:0] w_next_pc;
    pc_sel_e         w_sel;
    logic            w_push;
    logic            w_pop;
    logic            w_err_event;
    logic            w_call_req;
    logic            w_ret_req;
    logic [PC_W-1:0] w_stack_top;
    logic            w_stack_full;
    logic            w_stack_empty;

    Adder_10bit u_add_inc (
        .i_a   (r_pc),
        .i_b   (11'd1),
        .o_sum (w_pc_inc)
    );

    Adder_10bit u_add_br (
        .i_a   (r_pc),
        .i_b   (i_branch_off),
        .o_sum (w_pc_br)
    );

`ifdef PC_CALL_STACK_EN
    assign w_call_req = i_call;
    assign w_ret_req  = i_ret;

    pc_return_stack #(
        .PC_W  (PC_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (w_pc_inc),
        .o_top       (w_stack_top),
        .o_full      (w_stack_full),
        .o_empty     (w_stack_empty)
    );
`else
    localparam int unused_stack_depth = STACK_DEPTH;
    logic w_unused_call_ret;

    assign w_call_req        = 1'b0;
    assign w_ret_req         = 1'b0;
    assign w_stack_top       = {PC_W{1'b0}};
    assign w_stack_full      = 1'b0;
    assign w_stack_empty     = 1'b1;
    assign w_unused_call_ret = ^{i_call, i_ret, w_push, w_pop};
`endif

    // Choose the next-pc source; requests are only honoured in S_RUN without stall.
    always_comb begin
        w_sel       = SEL_HOLD;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_err_event = 1'b0;
        if ((r_state == S_RUN) && !i_stall) begin
            if (w_ret_req) begin
                w_sel       = SEL_RET;
                w_pop       = !w_stack_empty;
                w_err_event = w_stack_empty;
            end else if (w_call_req) begin
                w_sel       = SEL_JMP;
                w_push      = !w_stack_full;
                w_err_event = w_stack_full;
            end else if (i_jump) begin
                w_sel = SEL_JMP;
            end else if (i_branch_taken) begin
                w_sel = SEL_BR;
            end else begin
                w_sel = SEL_INC;
            end
        end else begin
            w_sel = SEL_HOLD;
        end
    end

    // Next-pc mux; an empty-stack return falls back to the reset address.
    always_comb begin
        w_next_pc = r_pc;
        case (w_sel)
            SEL_HOLD: w_next_pc = r_pc;
            SEL_INC:  w_next_pc = w_pc_inc;
            SEL_BR:   w_next_pc = w_pc_br;
            SEL_JMP:  w_next_pc = i_jump_addr;
            SEL_RET:  w_next_pc = w_stack_empty ? RESET_PC : w_stack_top;
            default:  w_next_pc = r_pc;
        endcase
    end

    // Sequencer FSM with registered pc, pc_valid, flush and sticky stack error.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_BOOT;
            r_pc        <= RESET_PC;
            r_pc_valid  <= 1'b0;
            r_flush     <= 1'b0;
            r_stack_err <= 1'b0;
        end else begin
            if (w_err_event) begin
                r_stack_err <= 1'b1;
            end
            case (r_state)
                S_BOOT: begin
                    r_flush <= 1'b0;
                    if (!i_stall) begin
                        r_state    <= S_RUN;
                        r_pc_valid <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_pc <= w_next_pc;
                    if (is_redirect(w_sel)) begin
                        r_state    <= S_BUBBLE;
                        r_pc_valid <= 1'b0;
                        r_flush    <= 1'b1;
                    end else begin
                        r_pc_valid <= 1'b1;
                        r_flush    <= 1'b0;
                    end
                end
                S_BUBBLE: begin
                    r_flush <= 1'b0;
                    if (!i_stall) begin
                        r_state    <= S_RUN;
                        r_pc_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_BOOT;
                    r_pc       <= RESET_PC;
                    r_pc_valid <= 1'b0;
                    r_flush    <= 1'b0;
                end
            endcase
        end
    end

    assign o_pc        = r_pc;
    assign o_pc_valid  = r_pc_valid;
    assign o_flush     = r_flush;
    assign o_stack_err = r_stack_err;

endmodule
